// File: rtl/div_sequencer_if.sv
// Request/response bundle between the EX stage and the iterative divide sequencer.
interface div_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic [1:0]       req_op;
    logic [XLEN-1:0]  req_a;
    logic [XLEN-1:0]  req_b;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] done_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, flush,
        input  stall, busy, done, result, done_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, flush,
        output stall, busy, done, result, done_tag
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU sequencer around a radix-2 restoring divider.
// Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    div_sequencer_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q;
    logic             op_rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;
    logic [TAG_W-1:0] done_tag_q;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? negate(v) : v;
    endfunction

    logic             accept;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic             ovf;
    logic [XLEN-1:0]  special_res;
    logic [XLEN:0]    shift_d;
    logic [XLEN:0]    diff_d;
    logic             ge_d;
    logic [XLEN-1:0]  rem_d;
    logic [XLEN-1:0]  quo_d;
    logic [XLEN-1:0]  result_d;

    always_comb begin
        accept      = (state_q == IDLE) && bus.req_valid && !bus.flush;
        is_signed   = ~bus.req_op[0];
        a_neg       = is_signed & bus.req_a[XLEN-1];
        b_neg       = is_signed & bus.req_b[XLEN-1];
        b_zero      = (bus.req_b == '0);
        ovf         = is_signed && (bus.req_a == INT_MIN) && (bus.req_b == '1);
        if (b_zero)
            special_res = bus.req_op[1] ? bus.req_a : '1;
        else
            special_res = bus.req_op[1] ? '0 : INT_MIN;

        // Partial remainder never exceeds the divisor, so bit XLEN of the
        // difference is a clean borrow flag.
        shift_d  = {rem_q, quo_q[XLEN-1]};
        diff_d   = shift_d - {1'b0, dvs_q};
        ge_d     = ~diff_d[XLEN];
        rem_d    = ge_d ? diff_d[XLEN-1:0] : shift_d[XLEN-1:0];
        quo_d    = {quo_q[XLEN-2:0], ge_d};

        result_d = op_rem_q ? cond_neg(rem_q, neg_rem_q) : cond_neg(quo_q, neg_quo_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            tag_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            done_tag_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        op_rem_q  <= bus.req_op[1];
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        tag_q     <= bus.req_tag;
                        rem_q     <= '0;
                        quo_q     <= cond_neg(bus.req_a, a_neg);
                        dvs_q     <= cond_neg(bus.req_b, b_neg);
                        cnt_q     <= CW'(XLEN);
                        busy_q    <= 1'b1;
                        if (b_zero || ovf) begin
                            result_q   <= special_res;
                            done_tag_q <= bus.req_tag;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1))
                            state_q <= FIX;
                    end
                end
                FIX: begin
                    if (bus.flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        result_q   <= result_d;
                        done_tag_q <= tag_q;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    // Result is already committed; flush and new requests wait for IDLE.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.stall    = accept || (state_q == CALC) || (state_q == FIX);
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.done_tag = done_tag_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized checks of div_sequencer against an arithmetic reference model.
module tb_div_sequencer;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    div_sequencer_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    div_sequencer #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_tag = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V divide semantics; SV signed division truncates toward zero as required.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output int lat);
        logic [31:0] q;
        logic [31:0] r;
        bit sgn;
        sgn = !op[0];
        if (b == 0) begin
            q = '1; r = a; lat = 1;
        end else if (sgn && a == MIN && b == 32'hFFFF_FFFF) begin
            q = MIN; r = 0; lat = 1;
        end else begin
            lat = XLEN + 2;
            if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
        res = op[1] ? r : q;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the done cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input string name);
        logic [31:0] er;
        int el;
        int lat;
        bit seen;
        bit hold_ok;
        model(op, a, b, er, el);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        bus.flush     = 1'b0;
        #1 chk({name, ".stall_req"}, 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_tag   = 5'($urandom);
        lat = 0;
        seen = 0;
        hold_ok = 1;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1;
            else if (!bus.stall || !bus.busy) hold_ok = 0;
        end
        chk({name, ".done_seen"}, 32'(seen), 32'd1);
        chk({name, ".stall_hold"}, 32'(hold_ok), 32'd1);
        chk({name, ".latency"}, 32'(lat), 32'(el));
        chk({name, ".result"}, bus.result, er);
        chk({name, ".tag"}, 32'(bus.done_tag), 32'(tag));
        chk({name, ".stall_done"}, 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk({name, ".done_pulse"}, 32'(bus.done), 32'd0);
        chk({name, ".busy_after"}, 32'(bus.busy), 32'd0);
        chk({name, ".result_hold"}, bus.result, er);
        last_res = er;
        last_tag = tag;
    endtask

    initial begin
        bit done_seen;
        int lat;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst.stall", 32'(bus.stall), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.result", bus.result, 32'd0);
        chk("rst.tag", 32'(bus.done_tag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 32'd100, 32'd7, 5'd3, "div_100_7");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, "rem_m7_2");
        run_op(2'b11, 32'd97, 32'd3, 5'd5, "remu_97_3");
        run_op(2'b01, 32'd12, 32'd3, 5'd6, "divu_12_3");
        run_op(2'b01, 32'd5, 32'd0, 5'd7, "divu_5_0");
        run_op(2'b10, 32'd5, 32'd0, 5'd8, "rem_5_0");
        run_op(2'b00, MIN, 32'hFFFF_FFFF, 5'd9, "div_ovf");
        run_op(2'b10, MIN, 32'hFFFF_FFFF, 5'd10, "rem_ovf");
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd11, "div_m100_7");

        // Request together with flush in IDLE must not be taken.
        bus.req_valid = 1'b1; bus.flush = 1'b1;
        bus.req_op = 2'b01; bus.req_a = 32'd50; bus.req_b = 32'd5; bus.req_tag = 5'd1;
        #1 chk("idle_flush.stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk("idle_flush.busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 1'b0; bus.flush = 1'b0;

        // Flush ten cycles into CALC.
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_a = 32'd1000; bus.req_b = 32'd3; bus.req_tag = 5'd17;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush_calc.busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_calc.busy", 32'(bus.busy), 32'd0);
        chk("flush_calc.result", bus.result, last_res);
        chk("flush_calc.tag", 32'(bus.done_tag), 32'(last_tag));
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen = 1;
        end
        chk("flush_calc.no_done", 32'(done_seen), 32'd0);
        run_op(2'b01, 32'd9, 32'd2, 5'd18, "divu_9_2");

        // Flush while in FIX (cycle XLEN+1 after accept).
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_a = 32'd500; bus.req_b = 32'd9; bus.req_tag = 5'd19;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        repeat (XLEN + 1) @(negedge clk);
        chk("flush_fix.stall", 32'(bus.stall), 32'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_fix.busy", 32'(bus.busy), 32'd0);
        chk("flush_fix.done", 32'(bus.done), 32'd0);
        chk("flush_fix.result", bus.result, last_res);

        // A request presented during DONE is ignored until IDLE.
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_a = 32'd77; bus.req_b = 32'd7; bus.req_tag = 5'd20;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        lat = 0; done_seen = 0;
        while (!done_seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.done) done_seen = 1;
        end
        chk("b2b.first_done", 32'(done_seen), 32'd1);
        chk("b2b.first_result", bus.result, 32'd11);
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_a = 32'd20; bus.req_b = 32'd4; bus.req_tag = 5'd21;
        #1 chk("b2b.stall_in_done", 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk("b2b.idle_busy", 32'(bus.busy), 32'd0);
        run_op(2'b01, 32'd20, 32'd4, 5'd21, "b2b_divu_20_4");

        // Asynchronous reset in the middle of CALC.
        bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_a = 32'd12345; bus.req_b = 32'd11; bus.req_tag = 5'd22;
        @(posedge clk); #1 bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.stall", 32'(bus.stall), 32'd0);
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.done", 32'(bus.done), 32'd0);
        chk("midrst.result", bus.result, 32'd0);
        chk("midrst.tag", 32'(bus.done_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'b00, 32'd12345, 32'd11, 5'd23, "post_rst_div");

        for (int i = 0; i < 25; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = MIN; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 20);
                4: b = -$urandom_range(1, 15);
                default: ;
            endcase
            run_op(op, a, b, 5'($urandom_range(0, 31)), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
